// File: rtl/sound_write_port_if.sv
// sound_write_port_if: host-side capture inputs and sn76489-side strobe outputs of the sound write port
// master drives address_bus/data_bus/memen/we and observes snd_data/snd_cs_n/snd_we_n/fifo_level/overflow;
// slave is the sound_write_port view of the same signals.
interface sound_write_port_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [15:0]   address_bus;
    logic [7:0]    data_bus;
    logic          memen;
    logic          we;
    logic [7:0]    snd_data;
    logic          snd_cs_n;
    logic          snd_we_n;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    modport master (
        output address_bus, data_bus, memen, we,
        input  snd_data, snd_cs_n, snd_we_n, fifo_level, overflow
    );
    modport slave (
        input  address_bus, data_bus, memen, we,
        output snd_data, snd_cs_n, snd_we_n, fifo_level, overflow
    );
endinterface

// File: rtl/sound_write_port.sv
// sound_write_port: buffers host writes to the sound window and replays them to sn76489 as cs/we strobes
// clk   : 100 MHz system clock, rising edge
// reset : synchronous, active low
// bus   : slave view; in  address_bus[15:0], data_bus[7:0], memen (low), we (low), all asynchronous to clk
//                     out snd_data[7:0], snd_cs_n, snd_we_n, fifo_level, overflow (sticky)
module sound_write_port #(
    parameter logic [15:0] BASE_ADDR    = 16'h8400,
    parameter logic [15:0] ADDR_MASK    = 16'hFE00,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          SETUP_CYCLES = 2,
    parameter int          WE_CYCLES    = 4,
    parameter int          GAP_CYCLES   = 32
) (
    input logic               clk,
    input logic               reset,
    sound_write_port_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SETUP_CYCLES + WE_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

    logic [1:0]    r_we_sync;
    logic [1:0]    r_memen_sync;
    logic          r_we_s_d;
    logic          r_hit;
    logic [7:0]    r_cap_data;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_snd_data;
    logic          r_cs_n;
    logic          r_we_n;
    logic          w_cs_n_nxt;
    logic          w_we_n_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_accept;

    // Bit 1 of each synchronizer is the clk-domain copy (we_s / memen_s).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we_sync    <= 2'b11;
            r_memen_sync <= 2'b11;
            r_we_s_d     <= 1'b1;
        end else begin
            r_we_sync    <= {r_we_sync[0], bus.we};
            r_memen_sync <= {r_memen_sync[0], bus.memen};
            r_we_s_d     <= r_we_sync[1];
        end
    end

    // The hit flag is consumed on the first we_s-high cycle, so clearing it there is safe.
    always_ff @(posedge clk) begin
        if (!reset)
            r_hit <= 1'b0;
        else if (!r_we_sync[1])
            r_hit <= !r_memen_sync[1] && ((bus.address_bus & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
        else
            r_hit <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!r_we_sync[1])
            r_cap_data <= bus.data_bus;
    end

    assign w_push   = r_hit && !r_we_s_d && r_we_sync[1];
    assign w_pop    = (r_state == IDLE) && (r_level != '0);
    assign w_full   = r_level == LW'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr] <= r_cap_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr    <= r_wr + AW'(w_accept);
            r_rd    <= r_rd + AW'(w_pop);
            r_level <= r_level + LW'(w_accept) - LW'(w_pop);
            if (w_push && !w_accept)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_pop ? SETUP : IDLE;
            SETUP:   w_state_nxt = (r_cnt == CW'(SETUP_CYCLES - 1)) ? STROBE : SETUP;
            STROBE:  w_state_nxt = (r_cnt == CW'(WE_CYCLES - 1)) ? HOLD : STROBE;
            HOLD:    w_state_nxt = GAP;
            GAP:     w_state_nxt = (r_cnt == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobe levels are decoded from the state being entered, then registered.
    always_comb begin
        w_cs_n_nxt = (w_state_nxt == IDLE) || (w_state_nxt == GAP);
        w_we_n_nxt = w_state_nxt != STROBE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snd_data <= 8'h00;
            r_cs_n     <= 1'b1;
            r_we_n     <= 1'b1;
        end else begin
            r_cs_n <= w_cs_n_nxt;
            r_we_n <= w_we_n_nxt;
            if (w_pop)
                r_snd_data <= r_mem[r_rd];
        end
    end

    assign bus.snd_data   = r_snd_data;
    assign bus.snd_cs_n   = r_cs_n;
    assign bus.snd_we_n   = r_we_n;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
endmodule
